// File: rtl/trojan_chk_pkg.sv
// Shared types and constants for the response checker.
// Holds the FSM state enum and the MISR step function.
package trojan_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int N_IN_DEF = 6;
  localparam int MISR_W   = 16;

  localparam logic [MISR_W-1:0] MISR_POLY_DEF = 16'h1021;
  localparam logic [MISR_W-1:0] MISR_SEED_DEF = 16'hFFFF;

  function automatic logic [MISR_W-1:0] misr_next(
    input logic [MISR_W-1:0] sig,
    input logic [MISR_W-1:0] poly,
    input logic [MISR_W-1:0] din
  );
    logic [MISR_W-1:0] fb;
    fb = sig[MISR_W-1] ? poly : '0;
    misr_next = {sig[MISR_W-2:0], 1'b0} ^ fb ^ din;
  endfunction

endpackage

// File: rtl/resp_check_seq_misr16.sv
// 16-bit multiple-input signature register.
// Seed load has priority over a compaction step.
module misr16
  import trojan_chk_pkg::*;
#(
  parameter logic [MISR_W-1:0] POLY = MISR_POLY_DEF,
  parameter logic [MISR_W-1:0] SEED = MISR_SEED_DEF
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_en,
  input  logic [MISR_W-1:0] i_data,
  output logic [MISR_W-1:0] o_sig
);

  logic [MISR_W-1:0] r_sig;

  // Signature register: clear, reseed, or compact one word.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_sig <= '0;
    end else if (i_load) begin
      r_sig <= SEED;
    end else if (i_en) begin
      r_sig <= misr_next(r_sig, POLY, i_data);
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/resp_check_seq.sv
// Exhaustive-stream response checker.
// Golden compare, order check, first-fail capture, MISR.
module resp_check_seq
  import trojan_chk_pkg::*;
#(
  parameter int                     N_IN      = N_IN_DEF,
  parameter logic [2**N_IN-1:0]     GOLDEN    = '0,
  parameter int                     ERR_W     = 7,
  parameter logic [MISR_W-1:0]      MISR_POLY = MISR_POLY_DEF,
  parameter logic [MISR_W-1:0]      MISR_SEED = MISR_SEED_DEF
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:N_IN-1]   pat,
  input  logic              resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              seq_err,
  output logic [N_IN-1:0]   first_fail,
  output logic              fail_seen,
  output logic [MISR_W-1:0] signature
);

  localparam logic [N_IN-1:0]  IDX_ONE  = 1;
  localparam logic [N_IN-1:0]  IDX_LAST = '1;
  localparam logic [ERR_W-1:0] ERR_ONE  = 1;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [ERR_W-1:0]  r_err_cnt;
  logic              r_seq_err;
  logic [N_IN-1:0]   r_first_fail;
  logic              r_fail_seen;
  logic [N_IN-1:0]   r_exp_idx;

  logic [N_IN-1:0]   w_v;
  logic              w_acc;
  logic              w_mis;
  logic              w_last;
  logic [ERR_W-1:0]  w_err_nxt;
  logic              w_seq_nxt;
  logic              w_pass_nxt;
  logic [MISR_W-1:0] w_mdata;

  // pat[0] is the leftmost bit, so it lands as the MSB here.
  assign w_v = pat;

  // A pair arriving with start is dropped by the restart.
  assign w_acc = (r_state == RUN) & r_in_ready
               & in_valid & ~start;

  assign w_mis  = resp != GOLDEN[w_v];
  assign w_last = r_exp_idx == IDX_LAST;

  assign w_err_nxt = (w_mis && !(&r_err_cnt))
                   ? r_err_cnt + ERR_ONE
                   : r_err_cnt;
  assign w_seq_nxt  = r_seq_err | (w_v != r_exp_idx);
  assign w_pass_nxt = (w_err_nxt == '0) & ~w_seq_nxt;

  assign w_mdata = MISR_W'({w_v, resp});

  // State register.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: start always (re)enters RUN.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        if (start) begin
          w_state_nxt = RUN;
        end else if (w_acc && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result counters and registered status outputs.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
      r_seq_err    <= 1'b0;
      r_first_fail <= '0;
      r_fail_seen  <= 1'b0;
      r_exp_idx    <= '0;
    end else if (start) begin
      r_in_ready   <= 1'b1;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
      r_seq_err    <= 1'b0;
      r_first_fail <= '0;
      r_fail_seen  <= 1'b0;
      r_exp_idx    <= '0;
    end else if (w_acc) begin
      r_err_cnt <= w_err_nxt;
      r_seq_err <= w_seq_nxt;
      r_exp_idx <= r_exp_idx + IDX_ONE;
      if (w_mis && !r_fail_seen) begin
        r_first_fail <= w_v;
        r_fail_seen  <= 1'b1;
      end
      if (w_last) begin
        r_in_ready <= 1'b0;
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
        r_pass     <= w_pass_nxt;
      end
    end
  end

  misr16 #(
    .POLY (MISR_POLY),
    .SEED (MISR_SEED)
  ) u_misr (
    .CK     (CK),
    .reset  (reset),
    .i_load (start),
    .i_en   (w_acc),
    .i_data (w_mdata),
    .o_sig  (signature)
  );

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err_cnt;
  assign seq_err    = r_seq_err;
  assign first_fail = r_first_fail;
  assign fail_seen  = r_fail_seen;

endmodule

// File: doc/resp_check_seq.md
Name: resp_check_seq

Overview:
- Response-side counterpart of the exhaustive-pattern stimulus benches used for trojan detection.
- Consumes the stream of (applied pattern, DUT single-bit response) pairs and checks each response against a golden truth table.
- Verifies the stream is in order and complete (0..2^N_IN-1), counts mismatches, captures the first failing pattern, and accumulates a MISR signature.
- Sits between a DUT wrapper and the results logger, so pass/fail is decided in hardware rather than by post-processing a text dump.

Parameters:
- N_IN, 6, number of DUT inputs; the stream covers 2^N_IN patterns.
- GOLDEN, 64'h0, expected response per pattern; bit k is the expected response for pattern value k; width 2^N_IN.
- ERR_W, 7, width of the mismatch counter; saturates at all-ones.
- MISR_POLY, 16'h1021, feedback polynomial of the 16-bit MISR.
- MISR_SEED, 16'hFFFF, MISR value loaded on start.

Ports:
- CK  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins or restarts a check run.
- in_valid  in  1  pattern/response pair present.
- in_ready  out  1  checker accepts a pair this cycle.
- pat  in  [0:N_IN-1]  applied pattern; pat[0] is the MSB of the pattern value.
- resp  in  1  DUT response for pat.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.
- pass  out  1  valid when done=1; set when err_cnt==0 and seq_err==0.
- err_cnt  out  ERR_W  saturating count of mismatches.
- seq_err  out  1  sticky flag for an out-of-order pattern.
- first_fail  out  N_IN  value of the first mismatching pattern.
- fail_seen  out  1  first_fail holds a captured value.
- signature  out  16  MISR contents.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs clear to 0: in_ready, busy, done, pass, err_cnt, seq_err, first_fail, fail_seen.
  - signature clears to 0.
  - exp_idx clears to 0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start moves to RUN. On the same edge: err_cnt, seq_err, fail_seen, first_fail and exp_idx clear to 0; signature loads MISR_SEED; done and pass clear to 0.
- RUN:
  - busy=1 and in_ready=1.
  - A pair is accepted on a cycle where in_valid=1 and in_ready=1.
  - On acceptance:
    - Let v be the unsigned value of pat. A mismatch is resp != GOLDEN[v].
    - On a mismatch, err_cnt increments and saturates at all-ones.
    - On a mismatch with fail_seen=0, first_fail<=v and fail_seen<=1.
    - If v != exp_idx, seq_err<=1 (sticky).
    - exp_idx increments and wraps at 2^N_IN.
    - signature <= (signature<<1) ^ (signature[15] ? MISR_POLY : 0) ^ zero-extended {v, resp}, with resp as the LSB.
  - Completion: an acceptance with exp_idx == 2^N_IN-1 moves to DONE. In the next cycle done=1, busy=0, in_ready=0, and pass reflects the final counters, including the mismatch from that last pair.
  - A cycle with in_valid=0 causes no change.
- DONE:
  - done, pass and all result outputs hold; in_valid is ignored.
  - start moves to RUN with the same clears as from IDLE.
- start during RUN restarts the run: counters clear and the signature reseeds. A pair presented in the same cycle as start is discarded.
- An asynchronous reset during RUN aborts the run. No partial results are retained.
- Latency: one cycle from acceptance to updated err_cnt, first_fail and signature.

Decomposition:
- Package trojan_chk_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default N_IN;
  - the MISR width constant 16 and the default polynomial/seed;
  - a helper function computing the MISR next-state.
- One sub-module, misr16, contains the signature register with seed-load and enable inputs. The FSM and the counters stay in resp_check_seq.

Test Plan:
- GOLDEN=64'h0. Start, then all 64 patterns in order with resp=0 -> done=1 one cycle after pattern 63; pass=1, err_cnt=0, seq_err=0, fail_seen=0.
- GOLDEN=64'h0. In-order stream with resp=1 only on patterns 5 and 40 -> err_cnt=2, first_fail=5, fail_seen=1, pass=0.
- In-order stream except patterns 10 and 11 swapped, responses correct -> seq_err=1, err_cnt=0, pass=0, done after 64 accepts.
- Random in_valid gaps on the error-free stream -> results and signature identical to the gap-free run; no acceptance while in_valid=0.
- start pulsed after 30 accepts, then a full clean stream -> results equal to a fresh clean run; signature equals the reference-model value.
- reset driven low mid-run at pattern 20 -> all outputs 0 immediately (asynchronous); after release and a start, a clean run gives pass=1.
